// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery exponent selector.
// Holds the default sizing of the exponentiation datapath and the helper
// functions that turn those sizes into block counts, exponent word counts
// and counter widths.
package montgomery_pkg;

  localparam int DEFAULT_REGISTER_SIZE = 32;
  localparam int DEFAULT_BITS_IN_NUM   = 2048;
  localparam int DEFAULT_NUM_SQUARES   = 2048;

  // Blocks carried per reduced number (NUM_BLOCKS).
  function automatic int num_blocks(input int bits_in_num, input int register_size);
    return bits_in_num / register_size;
  endfunction

  // Exponent words consumed per exponentiation (EXP_WORDS).
  function automatic int exp_words(input int num_squares, input int register_size);
    return num_squares / register_size;
  endfunction

  // Counter width that still gives a 1-bit counter when only one value exists.
  function automatic int ctr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/montgomery_exponent_selector_if.sv
// Stream and exponent-word bundle between the Montgomery squarer, the
// exponent source and the downstream multiplier.
//   master : drives the square stream and the exponent word, observes results
//   slave  : the selector itself
// Signals:
//   square_block_in / square_valid_in  : block-serial squares, LSB block first
//   exponent_block_in                  : current exponent word, LSB = lowest bit
//   consumed_exponent_out              : pulse, exponent word taken this cycle
//   selected_block/valid/last_out      : forwarded number stream
//   done_out / none_selected_out       : end of exponentiation, nothing forwarded
interface montgomery_exponent_selector_if
  import montgomery_pkg::*;
#(
  parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE
) ();

  logic [REGISTER_SIZE-1:0] square_block_in;
  logic                     square_valid_in;
  logic [REGISTER_SIZE-1:0] exponent_block_in;
  logic                     consumed_exponent_out;
  logic [REGISTER_SIZE-1:0] selected_block_out;
  logic                     selected_valid_out;
  logic                     selected_last_out;
  logic                     done_out;
  logic                     none_selected_out;

  modport master (
    output square_block_in,
    output square_valid_in,
    output exponent_block_in,
    input  consumed_exponent_out,
    input  selected_block_out,
    input  selected_valid_out,
    input  selected_last_out,
    input  done_out,
    input  none_selected_out
  );

  modport slave (
    input  square_block_in,
    input  square_valid_in,
    input  exponent_block_in,
    output consumed_exponent_out,
    output selected_block_out,
    output selected_valid_out,
    output selected_last_out,
    output done_out,
    output none_selected_out
  );

endinterface

// File: rtl/montgomery_exponent_selector.sv
// Montgomery exponent selector.
// Watches the block-serial stream of successive squares x^(2^i) and forwards
// only those numbers whose exponent bit i is set, so a downstream multiplier
// can accumulate x^e mod N. Exponent bits are fetched one word at a time.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset
//   bus     : montgomery_exponent_selector_if slave modport (stream, exponent
//             word handshake, forwarded stream, done/none_selected flags)
module montgomery_exponent_selector
  import montgomery_pkg::*;
#(
  parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE,
  parameter int BITS_IN_NUM   = DEFAULT_BITS_IN_NUM,
  parameter int NUM_SQUARES   = DEFAULT_NUM_SQUARES
) (
  input logic                          clk_in,
  input logic                          rst_in,
  montgomery_exponent_selector_if.slave bus
);

  localparam int NUM_BLOCKS = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int BLK_W      = ctr_width(NUM_BLOCKS);
  localparam int BIT_W      = ctr_width(REGISTER_SIZE);
  // Square counter = word index above bit index, so the low bits are bit_idx.
  localparam int SQ_W       = ctr_width(exp_words(NUM_SQUARES, REGISTER_SIZE)) + BIT_W;

  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(NUM_SQUARES - 1);

  logic [BLK_W-1:0]         block_ctr_q, block_ctr_d;
  logic [SQ_W-1:0]          square_ctr_q, square_ctr_d;
  logic [REGISTER_SIZE-1:0] word_q, word_d;
  logic                     sel_q, sel_d;
  logic                     any_selected_q, any_selected_d;
  logic [REGISTER_SIZE-1:0] sel_block_q, sel_block_d;
  logic                     sel_valid_q, sel_valid_d;
  logic                     sel_last_q, sel_last_d;
  logic                     done_q, done_d;
  logic                     none_q, none_d;

  logic [BIT_W-1:0] bit_idx;
  logic             first_block;
  logic             last_block;
  logic             last_square;
  logic             word_start;
  logic             sel;

  // The first block of every REGISTER_SIZE-th square fetches a fresh word;
  // its decision must come straight from the incoming word because the
  // register only holds it from the next cycle on.
  always_comb begin
    bit_idx     = square_ctr_q[BIT_W-1:0];
    first_block = (block_ctr_q == '0);
    last_block  = (block_ctr_q == BLK_LAST);
    last_square = (square_ctr_q == SQ_LAST);
    word_start  = first_block && (bit_idx == '0);

    if (!first_block) begin
      sel = sel_q;
    end else if (word_start) begin
      sel = bus.exponent_block_in[0];
    end else begin
      sel = word_q[bit_idx];
    end

    block_ctr_d    = block_ctr_q;
    square_ctr_d   = square_ctr_q;
    word_d         = word_q;
    sel_d          = sel_q;
    any_selected_d = any_selected_q;
    sel_block_d    = '0;
    sel_valid_d    = 1'b0;
    sel_last_d     = 1'b0;
    done_d         = 1'b0;
    none_d         = 1'b0;

    if (bus.square_valid_in) begin
      block_ctr_d = last_block ? '0 : block_ctr_q + BLK_W'(1);
      if (last_block) begin
        square_ctr_d = last_square ? '0 : square_ctr_q + SQ_W'(1);
      end
      if (word_start) begin
        word_d = bus.exponent_block_in;
      end
      if (first_block) begin
        sel_d = sel;
      end
      // Block 0 of square 0 opens a new exponentiation, discarding history.
      if (first_block && (square_ctr_q == '0)) begin
        any_selected_d = sel;
      end else if (sel) begin
        any_selected_d = 1'b1;
      end
      sel_valid_d = sel;
      sel_block_d = sel ? bus.square_block_in : '0;
      sel_last_d  = sel && last_block;
      done_d      = last_block && last_square;
      none_d      = last_block && last_square && !(any_selected_q || sel);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      block_ctr_q    <= '0;
      square_ctr_q   <= '0;
      word_q         <= '0;
      sel_q          <= 1'b0;
      any_selected_q <= 1'b0;
      sel_block_q    <= '0;
      sel_valid_q    <= 1'b0;
      sel_last_q     <= 1'b0;
      done_q         <= 1'b0;
      none_q         <= 1'b0;
    end else begin
      block_ctr_q    <= block_ctr_d;
      square_ctr_q   <= square_ctr_d;
      word_q         <= word_d;
      sel_q          <= sel_d;
      any_selected_q <= any_selected_d;
      sel_block_q    <= sel_block_d;
      sel_valid_q    <= sel_valid_d;
      sel_last_q     <= sel_last_d;
      done_q         <= done_d;
      none_q         <= none_d;
    end
  end

  // The consumed pulse is same-cycle so upstream can switch words on the next
  // cycle; it is suppressed while reset is held so every output reads 0.
  assign bus.consumed_exponent_out = bus.square_valid_in && word_start && !rst_in;
  assign bus.selected_block_out    = sel_block_q;
  assign bus.selected_valid_out    = sel_valid_q;
  assign bus.selected_last_out     = sel_last_q;
  assign bus.done_out              = done_q;
  assign bus.none_selected_out     = none_q;

endmodule
